// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, programmable
// baud divisor, sticky overflow flag and an "all sent" interrupt.
module uart_tx_mmio #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        tx,
  output logic        irq_empty
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;
  state_t        state_q, state_d;

  logic        fifo_full, fifo_empty;
  logic        wr_txdata, wr_status, wr_baud, rd_any;
  logic        push, pop, bit_end;
  logic [15:0] div_sel;
  logic [31:0] count_ext;
  logic [3:0]  status_cnt;
  logic        unused_bits;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign wr_txdata  = bus_sel && bus_we && (bus_addr[3:2] == 2'd0);
  assign wr_status  = bus_sel && bus_we && (bus_addr[3:2] == 2'd1);
  assign wr_baud    = bus_sel && bus_we && (bus_addr[3:2] == 2'd2);
  assign rd_any     = bus_sel && !bus_we;
  assign bit_end    = (cnt_q == 16'd0);
  // A divisor below 2 would make the counter reload underflow; clamp it.
  assign div_sel    = (baud_q < 16'd2) ? 16'd2 : baud_q;
  assign count_ext  = 32'(count_q);
  assign status_cnt = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

  // Serialiser: tx_d is the level for the next cycle, so tx is a clean flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        pop  = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q - 16'd1;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          pop     = !fifo_empty;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      div_d   = div_sel;
      cnt_d   = div_sel - 16'd1;
      state_d = S_START;
      tx_d    = 1'b0;
    end
  end

  // FIFO bookkeeping and register file.
  always_comb begin
    push     = wr_txdata && (!fifo_full || pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (wr_txdata && !push) begin
      ovf_d = 1'b1;
    end else if (wr_status && bus_wdata[3]) begin
      ovf_d = 1'b0;
    end

    baud_d = wr_baud ? bus_wdata[15:0] : baud_q;

    rdata_d = 32'd0;
    if (rd_any) begin
      case (bus_addr[3:2])
        2'd1:    rdata_d = {24'd0, status_cnt, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
        2'd2:    rdata_d = {16'd0, baud_q};
        default: rdata_d = 32'd0;
      endcase
    end

    irq_d = (state_d == S_IDLE) && (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= 16'(BAUD_DIV);
      div_q    <= 16'd0;
      cnt_q    <= 16'd0;
      shift_q  <= 8'd0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;
  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-based line model checked every cycle,
// plus hand-computed literal checks on registers and frame timing.
module tb_uart_tx_mmio;
  localparam int DIV0  = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        tx;
  logic        irq_empty;

  always #5 clk = ~clk;

  uart_tx_mmio #(.BAUD_DIV(DIV0), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of bytes, plus a queue of tx levels for the frames in flight.
  logic [7:0]  m_fifo[$];
  bit          m_line[$];
  int          m_baud;
  bit          m_ovf;
  bit          m_valid = 1'b0;
  bit          exp_tx, exp_irq;
  logic [31:0] exp_rdata, m_rd;
  logic [7:0]  m_byte;
  int          m_d, m_c;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_baud    = DIV0;
      m_ovf     = 1'b0;
      exp_tx    = 1'b1;
      exp_irq   = 1'b1;
      exp_rdata = 32'd0;
      m_valid   = 1'b1;
    end else begin
      m_rd = 32'd0;
      if (bus_sel && !bus_we) begin
        m_c = m_fifo.size();
        if (bus_addr[3:2] == 2'd1)
          m_rd = {24'd0, 4'((m_c > 15) ? 15 : m_c), m_ovf, (m_line.size() != 0),
                  (m_c == 0), (m_c == DEPTH)};
        else if (bus_addr[3:2] == 2'd2)
          m_rd = 32'(m_baud);
      end
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_fifo.size() > 0) begin
        m_byte = m_fifo.pop_front();
        m_d = (m_baud < 2) ? 2 : m_baud;
        for (int i = 0; i < m_d; i++) m_line.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < m_d; i++) m_line.push_back(m_byte[b]);
        for (int i = 0; i < m_d; i++) m_line.push_back(1'b1);
      end
      if (bus_sel && bus_we) begin
        case (bus_addr[3:2])
          2'd0: if (m_fifo.size() < DEPTH) m_fifo.push_back(bus_wdata[7:0]);
                else m_ovf = 1'b1;
          2'd1: if (bus_wdata[3]) m_ovf = 1'b0;
          2'd2: m_baud = int'(bus_wdata[15:0]);
          default: ;
        endcase
      end
      exp_tx    = (m_line.size() > 0) ? m_line[0] : 1'b1;
      exp_irq   = (m_line.size() == 0) && (m_fifo.size() == 0);
      exp_rdata = m_rd;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_tx", 32'(tx), 32'(exp_tx));
      check("cycle_irq_empty", 32'(irq_empty), 32'(exp_irq));
      check("cycle_rdata", bus_rdata, exp_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick(1);
    bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'd0; bus_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick(1);
    bus_sel = 1'b0; bus_addr = 4'd0;
    d = bus_rdata;
  endtask

  task automatic wait_idle(input string name, input int t0, input int exp_cycles);
    int k = 0;
    while (irq_empty !== 1'b1 && k < 3000) begin
      tick(1);
      k++;
    end
    check(name, 32'(cyc - t0), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int t0;
    int lows;

    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq_empty), 32'd1);
    check("reset_rdata", bus_rdata, 32'd0);

    bus_read(4'h8, rd);  check("read_baud_reset", rd, 32'd4);
    bus_read(4'hC, rd);  check("read_reserved", rd, 32'd0);
    bus_read(4'h0, rd);  check("read_txdata", rd, 32'd0);
    bus_read(4'h4, rd);  check("read_status_idle", rd, 32'h02);

    // Single byte 0x55 at 4 clocks per bit.
    bus_write(4'h0, 32'h55);
    t0 = cyc;
    check("single_tx_cycle1", 32'(tx), 32'd1);
    check("single_irq_low", 32'(irq_empty), 32'd0);
    tick(1);
    check("single_tx_start", 32'(tx), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(2);
      check($sformatf("single_bit%0d", k), 32'(tx), 32'(k % 2));
      if (k == 5) check("single_irq_mid", 32'(irq_empty), 32'd0);
      tick(2);
    end
    wait_idle("single_frame_len", t0, 41);

    // Ten back-to-back pushes: one popped at once, eight stored, one dropped.
    for (int i = 0; i < 10; i++) begin
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'(i);
      tick(1);
      if (i == 0) t0 = cyc;
    end
    bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0;
    bus_read(4'h4, rd);  check("ovf_status", rd, 32'h8D);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd);  check("ovf_cleared", rd, 32'h85);
    wait_idle("ovf_stream_len", t0, 1 + 9 * 40);

    // Baud change mid-frame applies from the next byte only.
    bus_write(4'h0, 32'hA3);
    t0 = cyc;
    bus_write(4'h0, 32'h5A);
    tick(10);
    bus_write(4'h8, 32'd8);
    wait_idle("baud_change_len", t0, 1 + 40 + 80);
    bus_read(4'h8, rd);  check("read_baud8", rd, 32'd8);

    // Divisor of 1 is clamped to 2 clocks per bit.
    bus_write(4'h8, 32'd1);
    bus_read(4'h8, rd);  check("read_baud1", rd, 32'd1);
    bus_write(4'h0, 32'h0F);
    t0 = cyc;
    wait_idle("baud_clamp_len", t0, 21);

    // Reset in data bit 3 of 0xFF with three bytes queued.
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'hFF);
    t0 = cyc;
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    bus_write(4'h0, 32'h33);
    tick(14);
    check("pre_reset_busy", 32'(irq_empty), 32'd0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_irq", 32'(irq_empty), 32'd1);
    bus_read(4'h4, rd);  check("midreset_status", rd, 32'h02);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    check("midreset_no_frames", 32'(lows), 32'd0);
    bus_read(4'h8, rd);  check("midreset_baud", rd, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
